// File: rtl/vga_line_out.sv
// rtl/vga_line_out.sv - VGA timing, line prefetch request, ping-pong line buffer and RGB444/sync pin driver
module vga_line_out #(
  parameter int H_ACT  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_ACT  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23
) (
  input  logic        CLK_40M,
  input  logic        SYS_RST_N,
  input  logic        PIX_DVLD,
  input  logic [15:0] PIX_DATA,
  output logic        SLCT_OUT_REQ,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        LINE_ERR
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(H_ACT + 2);
  localparam int MW = $clog2(2 * H_ACT);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);
  localparam logic [VW-1:0] V_PRE = VW'(V_ACT - 2);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [AW-1:0] A_FULL = AW'(H_ACT);
  localparam logic [AW-1:0] A_SAT = AW'(H_ACT + 1);
  localparam logic [MW-1:0] BANK1_OFS = MW'(H_ACT);

  // run_q stays low for the first edge after reset so that edge can issue the line-0 prefetch
  logic          run_q, run_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          fill_pend_q, fill_pend_d;
  logic          req_q, req_d;
  logic          err_q, err_d;
  logic          de_d1_q, de_d1_d;
  logic          hs_d1_q, hs_d1_d;
  logic          vs_d1_q, vs_d1_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;

  logic          boundary;
  logic          next_active;
  logic [AW-1:0] wr_addr_inc;
  logic          wr_en;
  logic          rd_en;
  logic [MW-1:0] wr_idx;
  logic [MW-1:0] rd_idx;

  logic [11:0]   line_mem [2*H_ACT];
  logic [11:0]   rd_data_q;
  logic          unused_pix;

  assign unused_pix = ^PIX_DATA[15:12];

  // Next-state for timing counters, request, bank swap, fill tracking and the display pipeline
  always_comb begin
    run_d       = 1'b1;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    boundary    = !run_q || (h_cnt_q == H_LAST);
    if (run_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    // The line starting at h_cnt_d==0 requests the line after it
    next_active = (v_cnt_d == V_LAST) || (v_cnt_d <= V_PRE);
    req_d       = (h_cnt_d == '0) && next_active;

    // Count includes a pixel arriving in the boundary cycle itself
    wr_addr_inc = (PIX_DVLD && (wr_addr_q != A_SAT)) ? wr_addr_q + 1'b1 : wr_addr_q;
    wr_en       = PIX_DVLD && (wr_addr_q < A_FULL);
    wr_idx      = MW'(wr_addr_q) + (wr_bank_q ? BANK1_OFS : '0);

    rd_bank_d   = rd_bank_q;
    wr_bank_d   = wr_bank_q;
    fill_pend_d = fill_pend_q;
    wr_addr_d   = wr_addr_inc;
    err_d       = 1'b0;
    if (boundary) begin
      wr_addr_d   = '0;
      fill_pend_d = req_d;
      if (fill_pend_q) begin
        rd_bank_d = wr_bank_q;
        wr_bank_d = rd_bank_q;
        err_d     = (wr_addr_inc != A_FULL);
      end
    end

    // Stage 1: RAM read and delayed DE/HS/VS; stage 2: gated output register
    rd_en   = (h_cnt_q < H_ACT_C);
    rd_idx  = MW'(h_cnt_q) + (rd_bank_q ? BANK1_OFS : '0);
    de_d1_d = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs_d1_d = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
    vs_d1_d = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);
    rgb_d   = de_d1_q ? rd_data_q : 12'h000;
    hs_d    = hs_d1_q;
    vs_d    = vs_d1_q;
  end

  // Control and output registers with asynchronous reset
  always_ff @(posedge CLK_40M or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      run_q       <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= V_LAST;
      rd_bank_q   <= 1'b0;
      wr_bank_q   <= 1'b1;
      wr_addr_q   <= '0;
      fill_pend_q <= 1'b0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
      de_d1_q     <= 1'b0;
      hs_d1_q     <= 1'b0;
      vs_d1_q     <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      run_q       <= run_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      rd_bank_q   <= rd_bank_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      fill_pend_q <= fill_pend_d;
      req_q       <= req_d;
      err_q       <= err_d;
      de_d1_q     <= de_d1_d;
      hs_d1_q     <= hs_d1_d;
      vs_d1_q     <= vs_d1_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  // Line buffer storage and synchronous read; contents are deliberately not reset
  always_ff @(posedge CLK_40M) begin
    if (wr_en) begin
      line_mem[wr_idx] <= PIX_DATA[11:0];
    end
    if (rd_en) begin
      rd_data_q <= line_mem[rd_idx];
    end
  end

  assign SLCT_OUT_REQ = req_q;
  assign LINE_ERR     = err_q;
  assign VGA_R        = rgb_q[11:8];
  assign VGA_G        = rgb_q[7:4];
  assign VGA_B        = rgb_q[3:0];
  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;

endmodule

// File: tb/tb_vga_line_out.sv
// tb/tb_vga_line_out.sv - reduced-geometry bench with a ping-pong reference model for vga_line_out
module tb_vga_line_out;

  localparam int H_ACT = 64, H_FP = 4, H_SYNC = 8, H_BP = 6;
  localparam int V_ACT = 12, V_FP = 1, V_SYNC = 2, V_BP = 3;
  localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dvld = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        req, err, hs, vs;
  logic [3:0]  r, g, b;

  vga_line_out #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .CLK_40M(clk), .SYS_RST_N(rst_n), .PIX_DVLD(dvld), .PIX_DATA(data),
    .SLCT_OUT_REQ(req), .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_HS(hs), .VGA_VS(vs), .LINE_ERR(err)
  );

  always #12 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int mode = 0;
  int k = 0;
  int mrd = 0;
  bit pend = 1'b0;
  int fill = 0;
  int burst_at = 0, burst_left = 0, burst_x = 0;
  int req_cnt = 0, hs_cnt = 0, vs_cnt = 0;
  logic [11:0] mbuf [2][H_ACT];
  bit          mknown [2][H_ACT];

  function automatic int line_of(input int nn);
    return ((nn / HT) + VT - 1) % VT;
  endfunction

  function automatic bit exp_req(input int nn);
    int l;
    l = line_of(nn);
    return ((nn % HT) == 0) && ((l == VT - 1) || (l <= V_ACT - 2));
  endfunction

  function automatic logic [11:0] bar_color(input int x);
    logic [11:0] tab [8];
    tab = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h888, 12'h00F};
    return tab[(x * 8) / H_ACT];
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at n=%0d: observed %h expected %h", tag, n, got, exp);
    end
  endtask

  task automatic cycle_step();
    int h, hh, ll, len;
    bit de, e_hs, e_vs, e_err;
    logic [11:0] px;
    @(negedge clk);
    h = n % HT;
    e_err = 1'b0;
    if (h == 0) begin
      if (pend) begin
        e_err = (fill != H_ACT);
        mrd = 1 - mrd;
      end
      fill = 0;
      pend = exp_req(n);
    end
    check("slct_out_req", 16'(req), 16'(exp_req(n)));
    check("line_err", 16'(err), 16'(e_err));
    de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; hh = 0;
    if (n >= 2) begin
      hh = (n - 2) % HT;
      ll = line_of(n - 2);
      de = (hh < H_ACT) && (ll < V_ACT);
      e_hs = (hh >= H_ACT + H_FP) && (hh <= H_ACT + H_FP + H_SYNC - 1);
      e_vs = (ll >= V_ACT + V_FP) && (ll <= V_ACT + V_FP + V_SYNC - 1);
    end
    check("vga_hs", 16'(hs), 16'(e_hs));
    check("vga_vs", 16'(vs), 16'(e_vs));
    if (!de) check("rgb_blank", 16'({r, g, b}), 16'h0000);
    else if (mknown[mrd][hh]) check("rgb_pixel", 16'({r, g, b}), 16'(mbuf[mrd][hh]));
    req_cnt += int'(req);
    hs_cnt += int'(hs);
    vs_cnt += int'(vs);

    if (exp_req(n)) begin
      case (k % 4)
        1: len = H_ACT - 1;
        3: len = H_ACT + 1;
        default: len = H_ACT;
      endcase
      burst_at = n + 2;
      burst_x = 0;
      burst_left = (mode == 0) ? H_ACT : len;
      k++;
    end else if (mode == 1 && burst_left == 0 && !pend && h == 10 && $urandom_range(0, 1) == 1) begin
      burst_at = n;
      burst_x = 0;
      burst_left = 3;
    end
    if (burst_left > 0 && n >= burst_at) begin
      px = (mode == 0 && burst_x < H_ACT) ? bar_color(burst_x) : 12'($urandom);
      dvld = 1'b1;
      data = {4'($urandom), px};
      if (fill < H_ACT) begin
        mbuf[1 - mrd][fill] = px;
        mknown[1 - mrd][fill] = 1'b1;
      end
      fill++;
      burst_x++;
      burst_left--;
    end else begin
      dvld = 1'b0;
      data = 16'($urandom);
    end
    n++;
  endtask

  task automatic reset_phase(input int cyc);
    rst_n = 1'b0;
    dvld = 1'b0;
    #1;
    check("rst_async_outputs", {req, err, hs, vs, r, g, b}, 16'h0000);
    repeat (cyc) begin
      @(negedge clk);
      check("rst_hold_outputs", {req, err, hs, vs, r, g, b}, 16'h0000);
    end
    rst_n = 1'b1;
    n = 0;
    mrd = 0;
    pend = 1'b0;
    fill = 0;
    burst_left = 0;
  endtask

  task automatic frame_totals(input string tag);
    check({tag, "_req_per_frame"}, 16'(req_cnt), 16'(V_ACT));
    check({tag, "_hs_per_frame"}, 16'(hs_cnt), 16'(VT * H_SYNC));
    check({tag, "_vs_per_frame"}, 16'(vs_cnt), 16'(V_SYNC * HT));
    req_cnt = 0; hs_cnt = 0; vs_cnt = 0;
  endtask

  initial begin
    #3;
    reset_phase(4);

    mode = 0;
    req_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    repeat (FRAME) cycle_step();
    frame_totals("bars");

    mode = 1;
    k = 0;
    repeat (FRAME) cycle_step();
    frame_totals("random");

    mode = 0;
    repeat (6 * HT + 17) cycle_step();
    reset_phase(3);

    mode = 1;
    k = 0;
    req_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    repeat (FRAME) cycle_step();
    frame_totals("after_reset");
    repeat (3 * HT) cycle_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
